// File: rtl/tone_sequencer.sv
// Multi-voice square-wave sequencer with envelope and 1-bit sigma-delta mix, paced by VGA ticks.
// Optional build macro SEQ_PING_PONG_EN makes the step index bounce 0..7..0 instead of wrapping.
module tone_sequencer #(
  parameter int unsigned NUM_VOICES   = 2,
  parameter int unsigned VOICE_OFFSET = 2,
  parameter int unsigned ENV_W        = 5,
  parameter int unsigned ENV_THRESH   = 10,
  parameter int unsigned STEP_LOG2    = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_tick,
  input  logic                  frame_tick,
  input  logic [1:0]            mode,
  output logic                  audio,
  output logic [2:0]            step_idx,
  output logic                  beat_pulse,
  output logic [ENV_W-1:0]      env_level,
  output logic [NUM_VOICES-1:0] voice_wave,
  output logic                  playing
);

  localparam int unsigned MixW = ENV_W + $clog2(NUM_VOICES);
  // A zero-width frame counter is kept as one bit pinned at zero, so every frame_tick steps.
  localparam int unsigned FcW  = (STEP_LOG2 == 0) ? 1 : STEP_LOG2;

  localparam logic [FcW-1:0]   FcMax   = FcW'((1 << STEP_LOG2) - 1);
  localparam logic [FcW-1:0]   FcOne   = FcW'(1);
  localparam logic [ENV_W-1:0] EnvPeak = '1;
  localparam logic [ENV_W-1:0] EnvOne  = ENV_W'(1);
  localparam logic [ENV_W-1:0] EnvThr  = ENV_W'(ENV_THRESH);
  localparam logic [2:0]       StepOne = 3'd1;

  typedef enum logic [1:0] {
    StStop,
    StPlay,
    StHold
  } state_e;

  function automatic logic [7:0] note_div(input logic [2:0] idx);
    logic [7:0] div;
    case (idx)
      3'd0:    div = 8'd60;
      3'd1:    div = 8'd54;
      3'd2:    div = 8'd48;
      3'd3:    div = 8'd45;
      3'd4:    div = 8'd40;
      3'd5:    div = 8'd36;
      3'd6:    div = 8'd32;
      default: div = 8'd30;
    endcase
    return div;
  endfunction

  state_e                  state_q, state_d;
  logic [FcW-1:0]          frame_cnt_q, frame_cnt_d;
  logic [2:0]              step_q, step_d;
  logic [ENV_W-1:0]        env_q, env_d;
  logic [7:0]              cnt_q [NUM_VOICES];
  logic [7:0]              cnt_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   wave_q, wave_d;
  logic [MixW-1:0]         acc_q, acc_d;
  logic                    audio_q, audio_d;
  logic                    beat_q, beat_d;
`ifdef SEQ_PING_PONG_EN
  logic                    dir_down_q, dir_down_d;
`endif

  logic                    run;
  logic                    clear;
  logic                    advance;
  logic                    gate;
  logic [MixW-1:0]         sum;
  logic                    carry;
  logic [MixW-1:0]         acc_sum;
  logic [7:0]              div;

  // Mode decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      StStop: begin
        if (mode == 2'b01) state_d = StPlay;
      end
      StPlay: begin
        if (mode == 2'b00)  state_d = StStop;
        else if (mode[1])   state_d = StHold;
      end
      StHold: begin
        if (mode == 2'b00)       state_d = StStop;
        else if (mode == 2'b01)  state_d = StPlay;
      end
      default: state_d = StStop;
    endcase
  end

  // Ticks are handled under the current state's rules; a STOP request overrides them.
  always_comb begin
    run     = (state_q == StPlay);
    clear   = (state_d == StStop);
    advance = run && frame_tick && (frame_cnt_q == FcMax);
  end

  // Tempo, step index and envelope
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    step_d      = step_q;
    env_d       = env_q;
    beat_d      = advance && !clear;
`ifdef SEQ_PING_PONG_EN
    dir_down_d  = dir_down_q;
`endif

    if (run && frame_tick) begin
      frame_cnt_d = advance ? '0 : frame_cnt_q + FcOne;
    end

    if (advance) begin
`ifdef SEQ_PING_PONG_EN
      if (!dir_down_q) begin
        if (step_q == 3'd7) begin
          step_d     = 3'd6;
          dir_down_d = 1'b1;
        end else begin
          step_d = step_q + StepOne;
        end
      end else begin
        if (step_q == 3'd0) begin
          step_d     = 3'd1;
          dir_down_d = 1'b0;
        end else begin
          step_d = step_q - StepOne;
        end
      end
`else
      step_d = step_q + StepOne;
`endif
    end

    if (state_q == StStop && state_d == StPlay) begin
      env_d = EnvPeak;
    end else if (run) begin
      if (advance) begin
        env_d = EnvPeak;
      end else if (frame_tick && env_q != '0) begin
        env_d = env_q - EnvOne;
      end
    end

    if (clear) begin
      frame_cnt_d = '0;
      step_d      = '0;
      env_d       = '0;
`ifdef SEQ_PING_PONG_EN
      dir_down_d  = 1'b0;
`endif
    end
  end

  // Per-voice oscillators; a step advance resets phase ahead of any line_tick.
  always_comb begin
    div = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      cnt_d[v]  = cnt_q[v];
      wave_d[v] = wave_q[v];
      div       = note_div(step_q + 3'(v * VOICE_OFFSET));
      if (run) begin
        if (advance) begin
          cnt_d[v]  = '0;
          wave_d[v] = 1'b0;
        end else if (line_tick) begin
          if (cnt_q[v] >= div) begin
            cnt_d[v]  = '0;
            wave_d[v] = ~wave_q[v];
          end else begin
            cnt_d[v] = cnt_q[v] + 8'd1;
          end
        end
      end
      if (clear) begin
        cnt_d[v]  = '0;
        wave_d[v] = 1'b0;
      end
    end
  end

  // First-order sigma-delta: the carry out of the accumulator is the audio bit.
  always_comb begin
    gate = (env_q > EnvThr);
    sum  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (wave_q[v] && gate) sum = sum + MixW'(env_q);
    end
    {carry, acc_sum} = {1'b0, acc_q} + {1'b0, sum};
    acc_d   = run ? acc_sum : acc_q;
    audio_d = run && (state_d == StPlay) && carry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StStop;
      frame_cnt_q <= '0;
      step_q      <= '0;
      env_q       <= '0;
      wave_q      <= '0;
      acc_q       <= '0;
      audio_q     <= 1'b0;
      beat_q      <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) cnt_q[v] <= '0;
`ifdef SEQ_PING_PONG_EN
      dir_down_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      step_q      <= step_d;
      env_q       <= env_d;
      wave_q      <= wave_d;
      acc_q       <= acc_d;
      audio_q     <= audio_d;
      beat_q      <= beat_d;
      for (int v = 0; v < NUM_VOICES; v++) cnt_q[v] <= cnt_d[v];
`ifdef SEQ_PING_PONG_EN
      dir_down_q  <= dir_down_d;
`endif
    end
  end

  assign audio      = audio_q;
  assign step_idx   = step_q;
  assign beat_pulse = beat_q;
  assign env_level  = env_q;
  assign voice_wave = wave_q;
  assign playing    = (state_q == StPlay);

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboarded bench for tone_sequencer: beats are checked by a monitor against queued steps,
// other behaviour by directed checks. Uses STEP_LOG2=5 so the envelope can fall below threshold.
module tb_tone_sequencer;

  localparam int NV = 2;
  localparam int EW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_tick = 1'b0;
  logic          frame_tick = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          audio;
  logic [2:0]    step_idx;
  logic          beat_pulse;
  logic [EW-1:0] env_level;
  logic [NV-1:0] voice_wave;
  logic          playing;

  int total = 0;
  int bad   = 0;
  int exp_q [$];

  tone_sequencer #(
    .NUM_VOICES  (NV),
    .VOICE_OFFSET(2),
    .ENV_W       (EW),
    .ENV_THRESH  (10),
    .STEP_LOG2   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_tick (line_tick),
    .frame_tick(frame_tick),
    .mode      (mode),
    .audio     (audio),
    .step_idx  (step_idx),
    .beat_pulse(beat_pulse),
    .env_level (env_level),
    .voice_wave(voice_wave),
    .playing   (playing)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every beat must match the next queued step, with the envelope freshly reloaded.
  always @(negedge clk) begin
    if (beat_pulse) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_unexpected: got beat at step %0d, expected no beat", step_idx);
      end else begin
        check("beat_step", step_idx, exp_q.pop_front());
        check("beat_env", env_level, 31);
      end
    end
  end

  task automatic frame_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int first0, second0, first1, second1, ones, toggles;
    logic [NV-1:0] prev;
    int seq [16];
`ifdef SEQ_PING_PONG_EN
    seq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
`else
    seq = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0};
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_step", step_idx, 0);
    check("rst_env", env_level, 0);
    check("rst_wave", voice_wave, 0);
    check("rst_playing", playing, 0);
    check("rst_audio", audio, 0);
    check("rst_beat", beat_pulse, 0);

    // Play with a line_tick every cycle: half-periods are divisor+1 ticks
    rst_n = 1'b1;
    mode = 2'b01;
    line_tick = 1'b1;
    first0 = -1; second0 = -1; first1 = -1; second1 = -1;
    prev = '0;
    for (int c = 1; c <= 300 && (second0 < 0 || second1 < 0); c++) begin
      @(negedge clk);
      if (voice_wave[0] != prev[0]) begin
        if (first0 < 0) first0 = c; else if (second0 < 0) second0 = c;
      end
      if (voice_wave[1] != prev[1]) begin
        if (first1 < 0) first1 = c; else if (second1 < 0) second1 = c;
      end
      prev = voice_wave;
    end
    check("playing", playing, 1);
    check("env_after_start", env_level, 31);
    check("v0_half_period", second0 - first0, 61);
    check("v1_half_period", second1 - first1, 49);

    // Freeze both waves high: sum=62 over a 64-state accumulator gives 62 ones per 64 cycles
    for (int c = 0; c < 300 && voice_wave != 2'b11; c++) @(negedge clk);
    line_tick = 1'b0;
    check("both_waves_high", voice_wave, 3);
    @(negedge clk);
    ones = 0;
    repeat (64) begin
      @(negedge clk);
      ones += int'(audio);
    end
    check("density_62_of_64", ones, 62);

    // Envelope decay per frame_tick
    frame_pulses(3);
    check("env_decay_3", env_level, 28);
    frame_pulses(18);
    check("env_at_thresh", env_level, 10);

    // Gate closed: no audio although the oscillators keep running
    line_tick = 1'b1;
    repeat (2) @(negedge clk);
    ones = 0;
    toggles = 0;
    prev = voice_wave;
    repeat (200) begin
      @(negedge clk);
      ones += int'(audio);
      if (voice_wave != prev) toggles++;
      prev = voice_wave;
    end
    line_tick = 1'b0;
    check("gated_audio_ones", ones, 0);
    check("gated_waves_toggle", toggles > 0, 1);

    // 32nd frame_tick of the step advances it
    exp_q.push_back(1);
    frame_pulses(11);
    check("step_after_advance", step_idx, 1);
    check("env_reload", env_level, 31);
    check("phase_reset", voice_wave, 0);
    check("beat_one_cycle", beat_pulse, 0);
    frame_pulses(3);
    check("env_decay_after_step", env_level, 28);

    // Step 1: voice1 divisor 45 toggles on the 46th tick, voice0 (54) not yet
    line_tick = 1'b1;
    repeat (47) @(negedge clk);
    line_tick = 1'b0;
    check("pre_hold_wave", voice_wave, 2'b10);

    // HOLD freezes everything and mutes audio even with ticks arriving
    mode = 2'b10;
    @(negedge clk);
    line_tick = 1'b1;
    frame_tick = 1'b1;
    ones = 0;
    repeat (20) begin
      @(negedge clk);
      ones += int'(audio);
    end
    line_tick = 1'b0;
    frame_tick = 1'b0;
    check("hold_audio_ones", ones, 0);
    check("hold_playing", playing, 0);
    check("hold_step", step_idx, 1);
    check("hold_env", env_level, 28);
    check("hold_wave", voice_wave, 2'b10);

    // Resume: voice0 counter continues from 47 and toggles on the 8th tick
    mode = 2'b01;
    @(negedge clk);
    check("resume_playing", playing, 1);
    line_tick = 1'b1;
    repeat (7) @(negedge clk);
    check("resume_wave_7", voice_wave, 2'b10);
    @(negedge clk);
    check("resume_wave_8", voice_wave, 2'b11);
    line_tick = 1'b0;
    frame_pulses(1);
    check("resume_env", env_level, 27);

    // STOP clears all outputs on the next edge; hold modes do not leave STOP
    mode = 2'b00;
    @(negedge clk);
    check("stop_step", step_idx, 0);
    check("stop_env", env_level, 0);
    check("stop_wave", voice_wave, 0);
    check("stop_audio", audio, 0);
    check("stop_beat", beat_pulse, 0);
    check("stop_playing", playing, 0);
    mode = 2'b10;
    repeat (5) @(negedge clk);
    check("stop_ignores_hold", playing, 0);

    // Step sequence over 16 advances with frame_tick held high
    mode = 2'b01;
    @(negedge clk);
    check("restart_env", env_level, 31);
    for (int i = 0; i < 16; i++) exp_q.push_back(seq[i]);
    frame_tick = 1'b1;
    repeat (512) @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("beats_outstanding", exp_q.size(), 0);
    check("final_step", step_idx, seq[15]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
